// File: rtl/path_oram_backend_stub_if.sv
// Frontend-side command/store/load bundle of the PathORAM backend.
// master = frontend, slave = backend (or the flat-memory stub).
interface path_oram_backend_stub_if #(
  parameter int ORAMU      = 32,
  parameter int ORAML      = 10,
  parameter int FEDWidth   = 64,
  parameter int BECMDWidth = 2
);
  logic [BECMDWidth-1:0] Command;
  logic [ORAMU-1:0]      PAddr;
  logic [ORAML-1:0]      CurrentLeaf;
  logic [ORAML-1:0]      RemappedLeaf;
  logic                  CommandValid;
  logic                  CommandReady;
  logic [FEDWidth-1:0]   StoreData;
  logic                  StoreValid;
  logic                  StoreReady;
  logic [FEDWidth-1:0]   LoadData;
  logic                  LoadValid;
  logic                  LoadReady;
  logic                  BlockNotFound;
  logic                  BlockNotFoundValid;

  modport master (
    output Command, PAddr, CurrentLeaf, RemappedLeaf, CommandValid,
    input  CommandReady,
    output StoreData, StoreValid,
    input  StoreReady,
    input  LoadData, LoadValid,
    output LoadReady,
    input  BlockNotFound, BlockNotFoundValid
  );

  modport slave (
    input  Command, PAddr, CurrentLeaf, RemappedLeaf, CommandValid,
    output CommandReady,
    input  StoreData, StoreValid,
    output StoreReady,
    output LoadData, LoadValid,
    input  LoadReady,
    output BlockNotFound, BlockNotFoundValid
  );
endinterface

// File: rtl/path_oram_backend_stub.sv
// Insecure flat-memory stand-in for the PathORAM backend: blocks live in on-chip
// RAM indexed by PAddr, with per-block valid/leaf tracking to catch frontend remap bugs.
module path_oram_backend_stub #(
  parameter int ORAMB       = 512,
  parameter int ORAMU       = 32,
  parameter int ORAML       = 10,
  parameter int FEDWidth    = 64,
  parameter int AddrBits    = 7,
  parameter int AccessDelay = 16,
  parameter int BECMDWidth  = 2
) (
  input  logic                    Clock,
  input  logic                    Reset,
  path_oram_backend_stub_if.slave bus,
  output logic [31:0]             AccessCount
);
  localparam int Chunks       = ORAMB / FEDWidth;
  localparam int CHUNK_BITS   = $clog2(Chunks);
  localparam int DEPTH        = 1 << AddrBits;
  localparam int DELAY_CYCLES = (AccessDelay == 0) ? 1 : AccessDelay;
  localparam int DCW          = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;

  localparam logic [BECMDWidth-1:0] CMD_UPDATE  = BECMDWidth'(0);
  localparam logic [BECMDWidth-1:0] CMD_APPEND  = BECMDWidth'(1);
  localparam logic [BECMDWidth-1:0] CMD_READ    = BECMDWidth'(2);

  typedef enum logic [2:0] {IDLE, DELAY, STORE, LOAD, DONE} state_t;

  state_t                  state_r;
  logic [BECMDWidth-1:0]   cmd_r;
  logic [AddrBits-1:0]     idx_r;
  logic                    oor_r;
  logic [ORAML-1:0]        cur_leaf_r;
  logic [ORAML-1:0]        new_leaf_r;
  logic [DCW-1:0]          delay_cnt_r;
  logic                    hit_r;
  logic [CHUNK_BITS-1:0]   wr_beat_r;
  logic [CHUNK_BITS:0]     rd_beat_r;
  logic                    command_ready_r;
  logic                    store_ready_r;
  logic                    load_valid_r;
  logic [FEDWidth-1:0]     load_data_r;
  logic                    bnf_r;
  logic                    bnf_valid_r;
  logic [DEPTH-1:0]        valid_r;
  logic [ORAML-1:0]        leaf_r [DEPTH];
  logic [31:0]             access_count_r;
  logic [FEDWidth-1:0]     mem [DEPTH*Chunks];

  logic is_append_s, is_store_cmd_s, lookup_hit_s, store_beat_s, store_write_s, load_adv_s, mem_we_s;

  // Command decode, lookup and handshake qualifiers.
  always_comb begin
    is_append_s    = (cmd_r == CMD_APPEND);
    is_store_cmd_s = (cmd_r == CMD_APPEND) || (cmd_r == CMD_UPDATE);
    lookup_hit_s   = valid_r[idx_r] && (leaf_r[idx_r] == cur_leaf_r) && !oor_r;
    store_beat_s   = (state_r == STORE) && store_ready_r && bus.StoreValid;
    store_write_s  = is_append_s ? !oor_r : hit_r;
    load_adv_s     = !load_valid_r || bus.LoadReady;
    mem_we_s       = store_beat_s && store_write_s && !Reset;
  end

  // Block data RAM write port; the read port is the LoadData register below.
  always_ff @(posedge Clock) begin
    if (mem_we_s) begin
      mem[{idx_r, wr_beat_r}] <= bus.StoreData;
    end
  end

  // Access sequencer with registered handshake outputs and block metadata.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r         <= IDLE;
      command_ready_r <= 1'b0;
      store_ready_r   <= 1'b0;
      load_valid_r    <= 1'b0;
      load_data_r     <= '0;
      bnf_r           <= 1'b0;
      bnf_valid_r     <= 1'b0;
      valid_r         <= '0;
      access_count_r  <= 32'd0;
      delay_cnt_r     <= '0;
      wr_beat_r       <= '0;
      rd_beat_r       <= '0;
      hit_r           <= 1'b0;
    end else begin
      bnf_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (command_ready_r && bus.CommandValid) begin
            cmd_r           <= bus.Command;
            idx_r           <= bus.PAddr[AddrBits-1:0];
            oor_r           <= |bus.PAddr[ORAMU-1:AddrBits];
            cur_leaf_r      <= bus.CurrentLeaf;
            new_leaf_r      <= bus.RemappedLeaf;
            delay_cnt_r     <= '0;
            command_ready_r <= 1'b0;
            state_r         <= DELAY;
          end else begin
            command_ready_r <= 1'b1;
          end
        end
        DELAY: begin
          if (delay_cnt_r == DCW'(DELAY_CYCLES - 1)) begin
            hit_r <= lookup_hit_s;
            if (!is_append_s) begin
              bnf_r       <= !lookup_hit_s;
              bnf_valid_r <= 1'b1;
            end
            if (is_store_cmd_s) begin
              wr_beat_r     <= '0;
              store_ready_r <= 1'b1;
              state_r       <= STORE;
            end else begin
              rd_beat_r <= '0;
              state_r   <= LOAD;
            end
          end else begin
            delay_cnt_r <= delay_cnt_r + DCW'(1);
          end
        end
        STORE: begin
          if (store_beat_s) begin
            wr_beat_r <= wr_beat_r + CHUNK_BITS'(1);
            if (wr_beat_r == CHUNK_BITS'(Chunks - 1)) begin
              store_ready_r <= 1'b0;
              if (store_write_s) begin
                leaf_r[idx_r] <= new_leaf_r;
                if (is_append_s) begin
                  valid_r[idx_r] <= 1'b1;
                end
              end
              state_r <= DONE;
            end
          end
        end
        LOAD: begin
          if (load_adv_s) begin
            if (rd_beat_r != (CHUNK_BITS+1)'(Chunks)) begin
              // Misses still stream a full block of zeros.
              load_data_r  <= hit_r ? mem[{idx_r, rd_beat_r[CHUNK_BITS-1:0]}] : '0;
              load_valid_r <= 1'b1;
              rd_beat_r    <= rd_beat_r + (CHUNK_BITS+1)'(1);
            end else begin
              load_valid_r <= 1'b0;
              load_data_r  <= '0;
              if (hit_r) begin
                if (cmd_r == CMD_READ) begin
                  leaf_r[idx_r] <= new_leaf_r;
                end else begin
                  valid_r[idx_r] <= 1'b0;
                end
              end
              state_r <= DONE;
            end
          end
        end
        DONE: begin
          access_count_r  <= access_count_r + 32'd1;
          command_ready_r <= 1'b1;
          state_r         <= IDLE;
        end
        default: begin
          command_ready_r <= 1'b0;
          state_r         <= IDLE;
        end
      endcase
    end
  end

  assign bus.CommandReady       = command_ready_r;
  assign bus.StoreReady         = store_ready_r;
  assign bus.LoadData           = load_data_r;
  assign bus.LoadValid          = load_valid_r;
  assign bus.BlockNotFound      = bnf_r;
  assign bus.BlockNotFoundValid = bnf_valid_r;
  assign AccessCount            = access_count_r;
endmodule

// File: tb/tb_path_oram_backend_stub.sv
// Directed bench for path_oram_backend_stub: append/read/remove/update flows,
// leaf checking, backpressure, stalled store data, mid-stream reset and out-of-range.
module tb_path_oram_backend_stub;
  localparam int D = 16;
  localparam logic [1:0] UPDATE = 2'd0, APPEND = 2'd1, READ = 2'd2, READRMV = 2'd3;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [31:0] access_count;

  path_oram_backend_stub_if #(.ORAMU(32), .ORAML(10), .FEDWidth(64), .BECMDWidth(2)) bus ();

  path_oram_backend_stub #(
    .ORAMB(512), .ORAMU(32), .ORAML(10), .FEDWidth(64),
    .AddrBits(7), .AccessDelay(D), .BECMDWidth(2)
  ) dut (
    .Clock(Clock), .Reset(Reset), .bus(bus), .AccessCount(access_count)
  );

  always #5 Clock = ~Clock;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          bnf_pulses = 0;
  logic        bnf_last = 1'b0;
  logic [63:0] rd_data [8];
  int          rd_cyc [8];
  int          rd_n;
  int          stall_bad;

  always @(negedge Clock) begin
    if (bus.BlockNotFoundValid === 1'b1) begin
      bnf_pulses <= bnf_pulses + 1;
      bnf_last   <= bus.BlockNotFound;
    end
  end

  task automatic send_cmd(input logic [1:0] cmd, input logic [31:0] paddr,
                          input logic [9:0] cur, input logic [9:0] remap);
    bit ok = 1'b0;
    @(negedge Clock);
    bus.Command = cmd; bus.PAddr = paddr; bus.CurrentLeaf = cur; bus.RemappedLeaf = remap;
    bus.CommandValid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (bus.CommandReady === 1'b1) begin ok = 1'b1; break; end
      @(negedge Clock);
    end
    n_cmp++;
    if (!ok) begin n_fail++; $display("FAIL cmd_accept: got no CommandReady, expected accept"); end
    @(negedge Clock);
    bus.CommandValid = 1'b0;
  endtask

  task automatic store_block(input logic [63:0] base);
    for (int k = 0; k < 8; k++) begin
      int g = 0;
      bus.StoreData = base + 64'(k);
      bus.StoreValid = 1'b1;
      while (bus.StoreReady !== 1'b1 && g < 300) begin @(negedge Clock); g++; end
      n_cmp++;
      if (g >= 300) begin n_fail++; $display("FAIL store_beat%0d: got no StoreReady, expected ready", k); end
      @(negedge Clock);
    end
    bus.StoreValid = 1'b0;
  endtask

  task automatic read_block(input bit toggle);
    int cyc = 1;
    int phase = 0;
    bit stalled = 1'b0;
    logic [63:0] held = '0;
    rd_n = 0; stall_bad = 0;
    bus.LoadReady = toggle ? 1'b0 : 1'b1;
    while (rd_n < 8 && cyc < 400) begin
      if (stalled && (bus.LoadValid !== 1'b1 || bus.LoadData !== held)) stall_bad++;
      stalled = 1'b0;
      if (bus.LoadValid === 1'b1) begin
        if (toggle) bus.LoadReady = (phase % 2 == 0);
        phase++;
        if (bus.LoadReady) begin
          rd_data[rd_n] = bus.LoadData; rd_cyc[rd_n] = cyc; rd_n++;
        end else begin
          stalled = 1'b1; held = bus.LoadData;
        end
      end
      @(negedge Clock); cyc++;
    end
    bus.LoadReady = 1'b0;
  endtask

  task automatic wait_idle();
    int g = 0;
    while (bus.CommandReady !== 1'b1 && g < 200) begin @(negedge Clock); g++; end
    n_cmp++;
    if (g >= 200) begin n_fail++; $display("FAIL idle_wait: got busy, expected CommandReady=1"); end
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    repeat (3) @(negedge Clock);
    n_cmp++; if (bus.CommandReady !== 1'b0) begin n_fail++; $display("FAIL rst_cmdready: got %b expected 0", bus.CommandReady); end
    n_cmp++; if (bus.StoreReady !== 1'b0) begin n_fail++; $display("FAIL rst_storeready: got %b expected 0", bus.StoreReady); end
    n_cmp++; if (bus.LoadValid !== 1'b0) begin n_fail++; $display("FAIL rst_loadvalid: got %b expected 0", bus.LoadValid); end
    n_cmp++; if (bus.LoadData !== 64'd0) begin n_fail++; $display("FAIL rst_loaddata: got %h expected 0", bus.LoadData); end
    n_cmp++; if ({bus.BlockNotFound, bus.BlockNotFoundValid} !== 2'b00) begin n_fail++; $display("FAIL rst_bnf: got %b%b expected 00", bus.BlockNotFound, bus.BlockNotFoundValid); end
    n_cmp++; if (access_count !== 32'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", access_count); end
    Reset = 1'b0;
    @(negedge Clock);
    n_cmp++; if (bus.CommandReady !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b expected 1", bus.CommandReady); end
  endtask

  task automatic test_append_read();
    int p0 = bnf_pulses;
    send_cmd(APPEND, 32'd3, 10'd0, 10'd5);
    store_block(64'd0);
    wait_idle();
    n_cmp++; if (bnf_pulses !== p0) begin n_fail++; $display("FAIL append_no_bnf: got %0d pulses expected 0", bnf_pulses - p0); end
    send_cmd(READ, 32'd3, 10'd5, 10'd5);
    read_block(1'b0);
    n_cmp++; if (rd_n !== 8) begin n_fail++; $display("FAIL ar_beats: got %0d expected 8", rd_n); end
    n_cmp++; if (rd_cyc[0] !== D + 2) begin n_fail++; $display("FAIL ar_latency: got %0d expected %0d", rd_cyc[0], D + 2); end
    n_cmp++; if (rd_cyc[7] - rd_cyc[0] !== 7) begin n_fail++; $display("FAIL ar_no_bubbles: got span %0d expected 7", rd_cyc[7] - rd_cyc[0]); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (rd_data[k] !== 64'(k)) begin n_fail++; $display("FAIL ar_data%0d: got %h expected %h", k, rd_data[k], 64'(k)); end
    end
    wait_idle();
    n_cmp++; if (bnf_pulses !== p0 + 1 || bnf_last !== 1'b0) begin n_fail++; $display("FAIL ar_bnf: got %0d/%b expected 1/0", bnf_pulses - p0, bnf_last); end
    n_cmp++; if (access_count !== 32'd2) begin n_fail++; $display("FAIL ar_count: got %0d expected 2", access_count); end
  endtask

  task automatic test_wrong_leaf();
    int p0 = bnf_pulses;
    send_cmd(READ, 32'd3, 10'd6, 10'd7);
    read_block(1'b0);
    wait_idle();
    n_cmp++; if (bnf_pulses !== p0 + 1 || bnf_last !== 1'b1) begin n_fail++; $display("FAIL wl_bnf: got %0d/%b expected 1/1", bnf_pulses - p0, bnf_last); end
    n_cmp++; if (rd_n !== 8) begin n_fail++; $display("FAIL wl_beats: got %0d expected 8", rd_n); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (rd_data[k] !== 64'd0) begin n_fail++; $display("FAIL wl_zero%0d: got %h expected 0", k, rd_data[k]); end
    end
    send_cmd(READ, 32'd3, 10'd5, 10'd5);
    read_block(1'b0);
    wait_idle();
    n_cmp++; if (bnf_last !== 1'b0) begin n_fail++; $display("FAIL wl_leaf_kept: got bnf %b expected 0", bnf_last); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (rd_data[k] !== 64'(k)) begin n_fail++; $display("FAIL wl_data%0d: got %h expected %h", k, rd_data[k], 64'(k)); end
    end
  endtask

  task automatic test_read_rmv();
    int p0;
    send_cmd(READRMV, 32'd3, 10'd5, 10'd5);
    read_block(1'b0);
    wait_idle();
    n_cmp++; if (bnf_last !== 1'b0) begin n_fail++; $display("FAIL rr_hit: got bnf %b expected 0", bnf_last); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (rd_data[k] !== 64'(k)) begin n_fail++; $display("FAIL rr_data%0d: got %h expected %h", k, rd_data[k], 64'(k)); end
    end
    send_cmd(READRMV, 32'd3, 10'd5, 10'd5);
    read_block(1'b0);
    wait_idle();
    n_cmp++; if (bnf_last !== 1'b1) begin n_fail++; $display("FAIL rr_removed: got bnf %b expected 1", bnf_last); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (rd_data[k] !== 64'd0) begin n_fail++; $display("FAIL rr_zero%0d: got %h expected 0", k, rd_data[k]); end
    end
    p0 = bnf_pulses;
    send_cmd(APPEND, 32'd3, 10'd0, 10'd4);
    store_block(64'h100);
    wait_idle();
    n_cmp++; if (bnf_pulses !== p0) begin n_fail++; $display("FAIL rr_append_no_bnf: got %0d pulses expected 0", bnf_pulses - p0); end
    send_cmd(READ, 32'd3, 10'd4, 10'd4);
    read_block(1'b0);
    wait_idle();
    n_cmp++; if (bnf_last !== 1'b0) begin n_fail++; $display("FAIL rr_restored: got bnf %b expected 0", bnf_last); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (rd_data[k] !== 64'h100 + 64'(k)) begin n_fail++; $display("FAIL rr_new%0d: got %h expected %h", k, rd_data[k], 64'h100 + 64'(k)); end
    end
  endtask

  task automatic test_update_stall();
    int hi = 0;
    send_cmd(UPDATE, 32'd3, 10'd4, 10'd9);
    repeat (99) begin
      @(negedge Clock);
      if (bus.StoreReady === 1'b1) hi++;
    end
    n_cmp++; if (hi !== 99 - (D - 1)) begin n_fail++; $display("FAIL up_ready_cycles: got %0d expected %0d", hi, 99 - (D - 1)); end
    store_block(64'd10000);
    wait_idle();
    n_cmp++; if (bnf_last !== 1'b0) begin n_fail++; $display("FAIL up_hit: got bnf %b expected 0", bnf_last); end
    send_cmd(UPDATE, 32'd3, 10'd1, 10'd2);
    store_block(64'hdead0000);
    wait_idle();
    n_cmp++; if (bnf_last !== 1'b1) begin n_fail++; $display("FAIL up_miss: got bnf %b expected 1", bnf_last); end
    send_cmd(READ, 32'd3, 10'd9, 10'd9);
    read_block(1'b0);
    wait_idle();
    n_cmp++; if (bnf_last !== 1'b0) begin n_fail++; $display("FAIL up_remapped: got bnf %b expected 0", bnf_last); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (rd_data[k] !== 64'd10000 + 64'(k)) begin n_fail++; $display("FAIL up_data%0d: got %0d expected %0d", k, rd_data[k], 10000 + k); end
    end
  endtask

  task automatic test_backpressure();
    send_cmd(READ, 32'd3, 10'd9, 10'd9);
    read_block(1'b1);
    wait_idle();
    n_cmp++; if (rd_n !== 8) begin n_fail++; $display("FAIL bp_beats: got %0d expected 8", rd_n); end
    n_cmp++; if (rd_cyc[7] - rd_cyc[0] + 1 !== 15) begin n_fail++; $display("FAIL bp_span: got %0d expected 15", rd_cyc[7] - rd_cyc[0] + 1); end
    n_cmp++; if (stall_bad !== 0) begin n_fail++; $display("FAIL bp_stable: got %0d unstable stalls expected 0", stall_bad); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (rd_data[k] !== 64'd10000 + 64'(k)) begin n_fail++; $display("FAIL bp_data%0d: got %0d expected %0d", k, rd_data[k], 10000 + k); end
    end
  endtask

  task automatic test_reset_midstream();
    int n = 0;
    int g = 0;
    send_cmd(READ, 32'd3, 10'd9, 10'd9);
    bus.LoadReady = 1'b1;
    while (g < 100) begin
      if (bus.LoadValid === 1'b1 && n == 4) break;
      if (bus.LoadValid === 1'b1) n++;
      @(negedge Clock); g++;
    end
    n_cmp++; if (n !== 4) begin n_fail++; $display("FAIL mr_reach_beat4: got %0d beats expected 4", n); end
    Reset = 1'b1;
    @(negedge Clock);
    n_cmp++; if (bus.LoadValid !== 1'b0) begin n_fail++; $display("FAIL mr_loadvalid: got %b expected 0", bus.LoadValid); end
    Reset = 1'b0;
    bus.LoadReady = 1'b0;
    @(negedge Clock);
    n_cmp++; if (bus.CommandReady !== 1'b1) begin n_fail++; $display("FAIL mr_cmdready: got %b expected 1", bus.CommandReady); end
    n_cmp++; if (access_count !== 32'd0) begin n_fail++; $display("FAIL mr_count: got %0d expected 0", access_count); end
    send_cmd(READ, 32'd3, 10'd9, 10'd9);
    read_block(1'b0);
    wait_idle();
    n_cmp++; if (bnf_last !== 1'b1) begin n_fail++; $display("FAIL mr_cleared: got bnf %b expected 1", bnf_last); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (rd_data[k] !== 64'd0) begin n_fail++; $display("FAIL mr_zero%0d: got %h expected 0", k, rd_data[k]); end
    end
  endtask

  task automatic test_oor();
    int p0;
    send_cmd(APPEND, 32'd0, 10'd0, 10'd1);
    store_block(64'h500);
    wait_idle();
    p0 = bnf_pulses;
    send_cmd(APPEND, 32'd128, 10'd0, 10'd1);
    store_block(64'h900);
    wait_idle();
    n_cmp++; if (bnf_pulses !== p0) begin n_fail++; $display("FAIL oor_no_bnf: got %0d pulses expected 0", bnf_pulses - p0); end
    n_cmp++; if (access_count !== 32'd3) begin n_fail++; $display("FAIL oor_count: got %0d expected 3", access_count); end
    send_cmd(READ, 32'd0, 10'd1, 10'd1);
    read_block(1'b0);
    wait_idle();
    n_cmp++; if (bnf_last !== 1'b0) begin n_fail++; $display("FAIL oor_alias_hit: got bnf %b expected 0", bnf_last); end
    for (int k = 0; k < 8; k++) begin
      n_cmp++; if (rd_data[k] !== 64'h500 + 64'(k)) begin n_fail++; $display("FAIL oor_alias%0d: got %h expected %h", k, rd_data[k], 64'h500 + 64'(k)); end
    end
    send_cmd(READ, 32'd128, 10'd1, 10'd1);
    read_block(1'b0);
    wait_idle();
    n_cmp++; if (bnf_last !== 1'b1) begin n_fail++; $display("FAIL oor_read_miss: got bnf %b expected 1", bnf_last); end
    n_cmp++; if (rd_data[0] !== 64'd0) begin n_fail++; $display("FAIL oor_zero: got %h expected 0", rd_data[0]); end
    n_cmp++; if (access_count !== 32'd5) begin n_fail++; $display("FAIL oor_final_count: got %0d expected 5", access_count); end
  endtask

  initial begin
    Reset = 1'b1;
    bus.Command = 2'd0; bus.PAddr = 32'd0; bus.CurrentLeaf = 10'd0; bus.RemappedLeaf = 10'd0;
    bus.CommandValid = 1'b0; bus.StoreData = 64'd0; bus.StoreValid = 1'b0; bus.LoadReady = 1'b0;
    test_reset();
    test_append_read();
    test_wrong_leaf();
    test_read_rmv();
    test_update_stall();
    test_backpressure();
    test_reset_midstream();
    test_oor();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
